// File: rtl/ram_scan_reader_if.sv
// Interface bundling the RAM read port, the consumer valid/ready stream and scan control/status.
// The master modport is the scan reader. The slave modport is the RAM and consumer side.
interface ram_scan_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] data_addr;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, stop, ram_q, data_ready,
    output ram_addr, ram_wren, data_out, data_addr, data_valid, busy, done
  );

  modport slave (
    output start, stop, ram_q, data_ready,
    input  ram_addr, ram_wren, data_out, data_addr, data_valid, busy, done
  );
endinterface

// File: rtl/ram_scan_reader.sv
// Scans RAM addresses 0..DEPTH-1 after a start pulse and presents each word over valid/ready.
// Optional feature macro: RAM_SCAN_LOOP_EN wraps to address 0 and scans continuously.
module ram_scan_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  ram_scan_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        LAT       = 3'(RD_LAT);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        wait_cnt;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] data_addr_q;
  logic              launch;
  logic              accept;
  logic              at_last;
  logic              busy_c;
  logic              valid_c;
  logic              done_c;

  // Stop always wins: a same-edge start or handshake is dropped.
  assign launch  = (state == IDLE || state == DONE) && bus.start && !bus.stop;
  assign accept  = (state == HOLD) && !bus.stop && bus.data_ready;
  assign at_last = (addr_q == LAST_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: default-assign every combinational output first so no path infers a latch.
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start && bus.stop) next_state = IDLE;
        else if (bus.start)        next_state = READ;
      end
      READ: begin
        if (bus.stop)             next_state = IDLE;
        else if (wait_cnt == '0)  next_state = HOLD;
      end
      HOLD: begin
        if (bus.stop) next_state = IDLE;
        else if (bus.data_ready) begin
`ifdef RAM_SCAN_LOOP_EN
          next_state = READ;
`else
          next_state = at_last ? DONE : READ;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef RAM_SCAN_LOOP_EN
  logic wrap_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap_pulse <= 1'b0;
    else       wrap_pulse <= accept && at_last;
  end
`endif

  always_comb begin
    busy_c  = (state == READ) || (state == HOLD);
    valid_c = (state == HOLD);
`ifdef RAM_SCAN_LOOP_EN
    done_c  = (state == DONE) || wrap_pulse;
`else
    done_c  = (state == DONE);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments, and every datapath register is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      wait_cnt    <= '0;
      data_q      <= '0;
      data_addr_q <= '0;
    end else if (launch) begin
      addr_q   <= '0;
      wait_cnt <= LAT;
    end else if (state == READ && !bus.stop) begin
      if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end else begin
        data_q      <= bus.ram_q;
        data_addr_q <= addr_q;
      end
    end else if (accept) begin
`ifdef RAM_SCAN_LOOP_EN
      addr_q   <= at_last ? '0 : addr_q + ADDR_W'(1);
      wait_cnt <= LAT;
`else
      if (!at_last) begin
        addr_q   <= addr_q + ADDR_W'(1);
        wait_cnt <= LAT;
      end
`endif
    end
  end

  assign bus.ram_addr   = addr_q;
  assign bus.ram_wren   = 1'b0;
  assign bus.data_out   = data_q;
  assign bus.data_addr  = data_addr_q;
  assign bus.data_valid = valid_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;

endmodule
